hop_chain_tester: RTL and testbench

Stimulus-and-check endpoint for the hop-chain routing benchmarks. It launches a one-cycle start pulse into each enabled flop chain, watches the chain outputs come back, and measures each lane's return latency in clock0 cycles. It reports per-lane latency, timeout and spurious-return errors, plus an overall pass flag. It sits beside the hop-chain block on the same clock, drives its start inputs and receives its chain-end outputs.

---
 rtl/hop_chain_tester.sv | 136 +++++++++++++
 tb/tb_hop_chain_tester.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/hop_chain_tester.sv
// Stimulus-and-check endpoint for hop-chain routing benchmarks: launches a start pulse
// into each enabled chain, measures per-lane return latency and flags timeout/spurious errors.
module hop_chain_tester #(
    parameter int LANES   = 4,
    parameter int EXP_LAT = 7,
    parameter int TIMEOUT = 15,
    parameter int CNT_W   = 4
) (
    input  logic                     clock0,
    input  logic                     rst1,
    input  logic                     run,
    input  logic [LANES-1:0]         lane_en,
    input  logic [LANES-1:0]         ret,
    output logic [LANES-1:0]         start,
    output logic                     busy,
    output logic                     done,
    output logic                     pass,
    output logic [LANES*CNT_W-1:0]   lat,
    output logic [LANES-1:0]         timeout_err,
    output logic [LANES-1:0]         lat_err,
    output logic [LANES-1:0]         spur_err
);

    localparam logic [CNT_W-1:0] EXP_V     = CNT_W'(EXP_LAT);
    localparam logic [CNT_W-1:0] TIMEOUT_V = CNT_W'(TIMEOUT);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LAUNCH,
        S_WAIT,
        S_DONE
    } state_t;

    state_t                 state;
    logic [CNT_W-1:0]       cnt;
    logic [LANES-1:0]       en_q;
    logic [LANES-1:0]       cap_q;
    logic [LANES-1:0]       spur_q;

    logic [LANES-1:0]       hit;
    logic [LANES-1:0]       cap_n;
    logic [LANES-1:0]       spur_n;
    logic [LANES-1:0]       lerr_n;
    logic [LANES*CNT_W-1:0] lat_n;
    logic [CNT_W-1:0]       cnt_inc;
    logic                   wait_exit;

    assign cnt_inc = (cnt == {CNT_W{1'b1}}) ? cnt : cnt + CNT_W'(1);

    // Next-cycle capture view, so the exit decision and the published results
    // include returns that land in the very cycle WAIT is left.
    // NOTE: every signal gets a default first so no latch is inferred.
    always_comb begin
        hit    = '0;
        cap_n  = cap_q;
        spur_n = spur_q;
        lat_n  = lat;
        lerr_n = '0;
        if (state == S_WAIT) begin
            hit    = ret & en_q & ~cap_q;
            cap_n  = cap_q | hit;
            spur_n = spur_q | (ret & ~hit);
            for (int i = 0; i < LANES; i++) begin
                if (hit[i]) lat_n[i*CNT_W +: CNT_W] = cnt;
            end
        end
        for (int i = 0; i < LANES; i++) begin
            lerr_n[i] = cap_n[i] && (lat_n[i*CNT_W +: CNT_W] != EXP_V);
        end
        wait_exit = (cap_n == en_q) || (cnt == TIMEOUT_V);
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clock0) begin
        if (rst1) begin
            state       <= S_IDLE;
            cnt         <= '0;
            en_q        <= '0;
            cap_q       <= '0;
            spur_q      <= '0;
            start       <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            pass        <= 1'b0;
            lat         <= '0;
            timeout_err <= '0;
            lat_err     <= '0;
            spur_err    <= '0;
        end else begin
            start <= '0;
            done  <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (run) begin
                        en_q        <= lane_en;
                        cap_q       <= '0;
                        spur_q      <= '0;
                        lat         <= '0;
                        timeout_err <= '0;
                        lat_err     <= '0;
                        spur_err    <= '0;
                        pass        <= 1'b0;
                        start       <= lane_en;
                        busy        <= 1'b1;
                        cnt         <= '0;
                        state       <= S_LAUNCH;
                    end
                end
                S_LAUNCH: begin
                    cnt   <= cnt_inc;
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    cnt    <= cnt_inc;
                    cap_q  <= cap_n;
                    spur_q <= spur_n;
                    lat    <= lat_n;
                    if (wait_exit) begin
                        done        <= 1'b1;
                        timeout_err <= en_q & ~cap_n;
                        lat_err     <= lerr_n;
                        spur_err    <= spur_n;
                        pass        <= ~|((en_q & ~cap_n) | lerr_n | spur_n);
                        state       <= S_DONE;
                    end
                end
                S_DONE: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_hop_chain_tester.sv
// Directed bench for hop_chain_tester; a delay-line model stands in for the hop chains,
// with a per-cycle table for extra injected returns.
module tb_hop_chain_tester;
    localparam int LANES   = 4;
    localparam int EXP_LAT = 7;
    localparam int TIMEOUT = 15;
    localparam int CNT_W   = 4;

    logic        clock0 = 1'b0;
    logic        rst1;
    logic        run;
    logic [3:0]  lane_en;
    logic [3:0]  ret;
    logic [3:0]  start;
    logic        busy;
    logic        done;
    logic        pass;
    logic [15:0] lat;
    logic [3:0]  timeout_err;
    logic [3:0]  lat_err;
    logic [3:0]  spur_err;

    logic [3:0]  hist [32] = '{default: '0};
    logic [3:0]  ret_chain;
    logic [3:0]  ret_force;
    logic [3:0]  force_tab [64];
    int          dly [LANES];
    int          rel;
    int          checks = 0;
    int          errors = 0;

    hop_chain_tester #(
        .LANES(LANES), .EXP_LAT(EXP_LAT), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)
    ) dut (
        .clock0(clock0), .rst1(rst1), .run(run), .lane_en(lane_en), .ret(ret),
        .start(start), .busy(busy), .done(done), .pass(pass), .lat(lat),
        .timeout_err(timeout_err), .lat_err(lat_err), .spur_err(spur_err)
    );

    always #5 clock0 = ~clock0;

    // Chain model: lane i returns its start pulse dly[i] cycles later (0 = never).
    always @(posedge clock0) begin
        hist[0] <= start;
        for (int i = 1; i < 32; i++) hist[i] <= hist[i-1];
    end

    always_comb begin
        ret_chain = '0;
        for (int i = 0; i < LANES; i++) begin
            if (dly[i] > 0) ret_chain[i] = hist[dly[i]-1][i];
        end
    end

    assign ret = ret_chain | ret_force;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock0);
        #1;
        rel++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic setup(input int d0, input int d1, input int d2, input int d3);
        foreach (force_tab[i]) force_tab[i] = '0;
        dly[0] = d0; dly[1] = d1; dly[2] = d2; dly[3] = d3;
    endtask

    task automatic launch(input logic [3:0] en);
        lane_en = en;
        run     = 1'b1;
        rel     = 0;
        tick();
        check("busy_rise", busy, 1);
        check("start_pulse", start, en);
        run = 1'b0;
    endtask

    task automatic wait_done();
        while (!done && rel < 40) begin
            ret_force = force_tab[rel];
            tick();
            if (rel == 2) check("start_drop", start, 0);
        end
        ret_force = '0;
        check("done_seen", done, 1);
    endtask

    task automatic results(input string name, input int done_rel, input logic [15:0] e_lat,
                           input logic [3:0] e_to, input logic [3:0] e_le,
                           input logic [3:0] e_sp, input logic e_pass);
        check({name, "_done_cycle"}, rel, done_rel);
        check({name, "_lat"}, lat, e_lat);
        check({name, "_timeout_err"}, timeout_err, e_to);
        check({name, "_lat_err"}, lat_err, e_le);
        check({name, "_spur_err"}, spur_err, e_sp);
        check({name, "_pass"}, pass, e_pass);
        tick();
        check({name, "_busy_fall"}, busy, 0);
        check({name, "_done_drop"}, done, 0);
        check({name, "_pass_hold"}, pass, e_pass);
    endtask

    initial begin
        int nstart, ndone, d1, d2;
        rst1 = 1'b1; run = 1'b0; lane_en = '0; ret_force = '0; rel = 0;
        setup(7, 7, 7, 7);
        idle(2);
        check("rst_busy", busy, 0);
        check("rst_start", start, 0);
        check("rst_done", done, 0);
        check("rst_pass", pass, 0);
        check("rst_lat", lat, 0);
        check("rst_errs", {timeout_err, lat_err, spur_err}, 0);
        rst1 = 1'b0;
        idle(3);

        // Nominal: all lanes depth 7.
        launch(4'b1111);
        wait_done();
        results("nominal", 9, 16'h7777, 4'b0000, 4'b0000, 4'b0000, 1'b1);
        idle(12);

        // Lane 2 returns two cycles late.
        setup(7, 7, 9, 7);
        launch(4'b1111);
        wait_done();
        results("mistimed", 11, 16'h7977, 4'b0000, 4'b0100, 4'b0000, 1'b0);
        idle(12);

        // Lane 1 never returns.
        setup(7, 0, 7, 7);
        launch(4'b1111);
        wait_done();
        results("timeout", 17, 16'h7707, 4'b0010, 4'b0000, 4'b0000, 1'b0);
        idle(12);

        // Disabled lane 3 pulses at cnt=5; lane 0 held high at cnt=6,7.
        setup(0, 7, 7, 7);
        force_tab[6] = 4'b1000;
        force_tab[7] = 4'b0001;
        force_tab[8] = 4'b0001;
        launch(4'b0111);
        wait_done();
        results("spurious", 9, 16'h0776, 4'b0000, 4'b0001, 4'b1001, 1'b0);
        idle(12);

        // run held high: re-accepted right after DONE, no extra launches while busy.
        setup(7, 7, 7, 7);
        lane_en = 4'b1111;
        run = 1'b1;
        rel = 0;
        nstart = 0; ndone = 0; d1 = 0; d2 = 0;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (start != 0) nstart++;
            if (done) begin
                if (ndone == 0) d1 = rel;
                else d2 = rel;
                ndone++;
            end
            if (rel == 11) check("b2b_restart", start, 4'hf);
            if (rel == 19) run = 1'b0;
        end
        check("b2b_start_count", nstart, 2);
        check("b2b_done_count", ndone, 2);
        check("b2b_first_done", d1, 9);
        check("b2b_second_done", d2, 19);
        check("b2b_pass", pass, 1);
        check("b2b_idle_after", busy, 0);
        idle(12);

        // Reset in the middle of a test at cnt=3.
        launch(4'b1111);
        idle(3);
        check("midrst_cnt_cycle", rel, 4);
        rst1 = 1'b1;
        run  = 1'b1;
        tick();
        check("midrst_busy", busy, 0);
        check("midrst_start", start, 0);
        check("midrst_done", done, 0);
        check("midrst_pass", pass, 0);
        check("midrst_lat", lat, 0);
        check("midrst_errs", {timeout_err, lat_err, spur_err}, 0);
        tick();
        check("midrst_run_ignored", {busy, start}, 0);
        rst1 = 1'b0;
        run  = 1'b0;
        idle(12);
        launch(4'b1111);
        wait_done();
        results("rerun", 9, 16'h7777, 4'b0000, 4'b0000, 4'b0000, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
